// File: rtl/cmd_decoder_param.sv
// Decodes the synchronised 32-bit PS->PL command word into a gated trigger
// pulse, NUM_REGS configuration registers with write strobes and a status word.
module cmd_decoder_param #(
    parameter int NUM_REGS    = 3,
    parameter int DATA_W      = 24,
    parameter int TRIG_LEN    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  data_input,
    input  logic                         busy_i,
    output logic                         cpu_trig,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          reg_wr_o,
    output logic [31:0]                  status_o,
    output logic [7:0]                   led_o
);

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_TRIG    = 2'd3;

    localparam int TW = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam int IW = $clog2(SYNC_STAGES + 1);

    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] sw;

    logic [1:0]                  state_q,     state_d;
    logic [IW-1:0]               init_cnt_q,  init_cnt_d;
    logic                        ack_q,       ack_d;
    logic [31:0]                 cap_q,       cap_d;
    logic [TW-1:0]               trig_cnt_q,  trig_cnt_d;
    logic                        trig_q,      trig_d;
    logic [NUM_REGS*DATA_W-1:0]  regs_q,      regs_d;
    logic [NUM_REGS-1:0]         wr_q,        wr_d;
    logic                        err_flag_q,  err_flag_d;
    logic [7:0]                  err_cnt_q,   err_cnt_d;
    logic [15:0]                 cmd_cnt_q,   cmd_cnt_d;
    logic [5:0]                  last_addr_q, last_addr_d;
    logic                        led_trig_q,  led_trig_d;
    logic [5:0]                  led_data_q,  led_data_d;

    logic                        hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= data_input;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sw = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ack_d       = ack_q;
        cap_d       = cap_q;
        trig_cnt_d  = trig_cnt_q;
        trig_d      = trig_q;
        regs_d      = regs_q;
        wr_d        = '0;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        cmd_cnt_d   = cmd_cnt_q;
        last_addr_d = last_addr_q;
        led_trig_d  = led_trig_q;
        led_data_d  = led_data_q;
        hit         = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Adopt the current flag so a word already present is not replayed
                if (init_cnt_q == IW'(SYNC_STAGES)) begin
                    ack_d   = sw[31];
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            ST_IDLE: begin
                trig_d = 1'b0;
                if (sw[31] != ack_q) begin
                    cap_d   = sw;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sw != cap_q) begin
                    cap_d = sw;
                end else begin
                    ack_d       = cap_q[31];
                    cmd_cnt_d   = cmd_cnt_q + 16'd1;
                    last_addr_d = cap_q[30:25];
                    err_flag_d  = 1'b0;
                    led_trig_d  = 1'b0;
                    state_d     = ST_IDLE;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (cap_q[30:25] == 6'(63 - i)) begin
                            hit = 1'b1;
                            regs_d[i*DATA_W +: DATA_W] = cap_q[DATA_W-1:0];
                            wr_d[i] = 1'b1;
                        end
                    end
                    if (cap_q[30:25] == 6'd0 && !cap_q[24]) begin
                        err_cnt_d = 8'd0;
                    end else if (cap_q[30:25] == 6'd0 && !busy_i) begin
                        trig_d     = 1'b1;
                        trig_cnt_d = TW'(TRIG_LEN - 1);
                        led_trig_d = 1'b1;
                        state_d    = ST_TRIG;
                    end else if (hit) begin
                        led_data_d = cap_q[5:0];
                    end else begin
                        err_flag_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            ST_TRIG: begin
                if (trig_cnt_q == '0) begin
                    trig_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    trig_cnt_d = trig_cnt_q - TW'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            ack_q       <= 1'b0;
            cap_q       <= '0;
            trig_cnt_q  <= '0;
            trig_q      <= 1'b0;
            regs_q      <= '0;
            wr_q        <= '0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
            cmd_cnt_q   <= '0;
            last_addr_q <= '0;
            led_trig_q  <= 1'b0;
            led_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ack_q       <= ack_d;
            cap_q       <= cap_d;
            trig_cnt_q  <= trig_cnt_d;
            trig_q      <= trig_d;
            regs_q      <= regs_d;
            wr_q        <= wr_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
            cmd_cnt_q   <= cmd_cnt_d;
            last_addr_q <= last_addr_d;
            led_trig_q  <= led_trig_d;
            led_data_q  <= led_data_d;
        end
    end

    assign cpu_trig = trig_q;
    assign regs_o   = regs_q;
    assign reg_wr_o = wr_q;
    assign status_o = {ack_q, last_addr_q, err_flag_q, err_cnt_q, cmd_cnt_q};
    assign led_o    = {sw[31], led_trig_q, led_data_q};

endmodule

// File: tb/tb_cmd_decoder_param.sv
// Directed bench for cmd_decoder_param (NUM_REGS=3, DATA_W=24, TRIG_LEN=3, SYNC_STAGES=2).
module tb_cmd_decoder_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_input;
    logic        busy_i;
    logic        cpu_trig;
    logic [71:0] regs_o;
    logic [2:0]  reg_wr_o;
    logic [31:0] status_o;
    logic [7:0]  led_o;

    int   n_vec = 0;
    int   n_err = 0;
    logic flag;

    cmd_decoder_param #(
        .NUM_REGS(3), .DATA_W(24), .TRIG_LEN(3), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .data_input(data_input), .busy_i(busy_i),
        .cpu_trig(cpu_trig), .regs_o(regs_o), .reg_wr_o(reg_wr_o),
        .status_o(status_o), .led_o(led_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] d);
        rst = 1'b1;
        data_input = d;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_input = 32'h8000_0000;
        busy_i = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({cpu_trig, reg_wr_o, status_o, led_o} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got trig=%b wr=%b status=%h led=%h, expected all 0",
                     cpu_trig, reg_wr_o, status_o, led_o);
        end
        n_vec++;
        if (regs_o !== 72'h0) begin
            n_err++;
            $display("FAIL reset_regs: got %h expected 0", regs_o);
        end
        rst = 1'b0;
        tick();
        tick();
        n_vec++;
        if (status_o !== 32'h0) begin
            n_err++;
            $display("FAIL init_wait: got status %h expected 00000000", status_o);
        end
        tick();
        n_vec++;
        if (status_o !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL init_ack: got status %h expected 80000000", status_o);
        end
        repeat (4) tick();
        n_vec++;
        if (status_o !== 32'h8000_0000 || regs_o !== 72'h0 || reg_wr_o !== 3'b000) begin
            n_err++;
            $display("FAIL init_no_exec: got status %h regs %h wr %b expected 80000000/0/000",
                     status_o, regs_o, reg_wr_o);
        end
        n_vec++;
        if (led_o !== 8'h80) begin
            n_err++;
            $display("FAIL init_led: got %h expected 80", led_o);
        end
    endtask

    task automatic test_write();
        do_reset(32'h0);
        data_input = 32'hFE00_03E8;
        repeat (3) tick();
        n_vec++;
        if (reg_wr_o !== 3'b000 || regs_o !== 72'h0) begin
            n_err++;
            $display("FAIL write_early: got wr %b regs %h expected 000/0", reg_wr_o, regs_o);
        end
        tick();
        n_vec++;
        if (reg_wr_o !== 3'b001 || regs_o[23:0] !== 24'd1000) begin
            n_err++;
            $display("FAIL write_reg0: got wr %b reg0 %h expected 001/0003e8", reg_wr_o, regs_o[23:0]);
        end
        n_vec++;
        if (status_o !== 32'hFE00_0001) begin
            n_err++;
            $display("FAIL write_status: got %h expected fe000001", status_o);
        end
        n_vec++;
        if (led_o !== 8'hA8) begin
            n_err++;
            $display("FAIL write_led: got %h expected a8", led_o);
        end
        tick();
        n_vec++;
        if (reg_wr_o !== 3'b000 || regs_o[23:0] !== 24'd1000) begin
            n_err++;
            $display("FAIL write_strobe_len: got wr %b reg0 %h expected 000/0003e8", reg_wr_o, regs_o[23:0]);
        end
        data_input = 32'h7C12_3456;
        repeat (4) tick();
        n_vec++;
        if (reg_wr_o !== 3'b010 || regs_o[47:24] !== 24'h123456 || status_o !== 32'h7C00_0002) begin
            n_err++;
            $display("FAIL write_reg1: got wr %b reg1 %h status %h expected 010/123456/7c000002",
                     reg_wr_o, regs_o[47:24], status_o);
        end
        data_input = 32'hFAAB_CDEF;
        repeat (4) tick();
        n_vec++;
        if (reg_wr_o !== 3'b100 || regs_o !== {24'hABCDEF, 24'h123456, 24'd1000}
            || status_o !== 32'hFA00_0003 || led_o !== 8'hAF) begin
            n_err++;
            $display("FAIL write_reg2: got wr %b regs %h status %h led %h expected 100/abcdef1234560003e8/fa000003/af",
                     reg_wr_o, regs_o, status_o, led_o);
        end
    endtask

    task automatic test_trigger();
        int pulses;
        busy_i = 1'b0;
        data_input = 32'h0100_0000;
        repeat (3) tick();
        n_vec++;
        if (cpu_trig !== 1'b0) begin
            n_err++;
            $display("FAIL trig_early: got %b expected 0", cpu_trig);
        end
        tick();
        n_vec++;
        if (cpu_trig !== 1'b1 || status_o !== 32'h0000_0004 || led_o !== 8'h6F) begin
            n_err++;
            $display("FAIL trig_start: got trig %b status %h led %h expected 1/00000004/6f",
                     cpu_trig, status_o, led_o);
        end
        tick();
        busy_i = 1'b1;
        n_vec++;
        if (cpu_trig !== 1'b1) begin
            n_err++;
            $display("FAIL trig_cycle2: got %b expected 1", cpu_trig);
        end
        tick();
        n_vec++;
        if (cpu_trig !== 1'b1) begin
            n_err++;
            $display("FAIL trig_cycle3_busy_ignored: got %b expected 1", cpu_trig);
        end
        tick();
        n_vec++;
        if (cpu_trig !== 1'b0) begin
            n_err++;
            $display("FAIL trig_end: got %b expected 0", cpu_trig);
        end
        data_input = 32'h8100_0000;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (cpu_trig) pulses++;
            if (i == 4) begin
                n_vec++;
                if (status_o !== 32'h8101_0005) begin
                    n_err++;
                    $display("FAIL trig_refused_status: got %h expected 81010005", status_o);
                end
            end
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL trig_refused_pulse: got %0d pulse cycles expected 0", pulses);
        end
        busy_i = 1'b0;
    endtask

    task automatic test_error();
        data_input = 32'h7000_0005;
        repeat (4) tick();
        n_vec++;
        if (reg_wr_o !== 3'b000 || regs_o !== {24'hABCDEF, 24'h123456, 24'd1000}) begin
            n_err++;
            $display("FAIL bad_addr_regs: got wr %b regs %h expected unchanged", reg_wr_o, regs_o);
        end
        n_vec++;
        if (status_o !== 32'h7102_0006) begin
            n_err++;
            $display("FAIL bad_addr_status: got %h expected 71020006", status_o);
        end
        data_input = 32'h8000_0000;
        repeat (4) tick();
        n_vec++;
        if (status_o !== 32'h8000_0007) begin
            n_err++;
            $display("FAIL clear_err: got %h expected 80000007", status_o);
        end
        // 256 invalid commands: count must stop at 255
        flag = 1'b1;
        for (int k = 0; k < 256; k++) begin
            flag = ~flag;
            data_input = {flag, 6'd56, 1'b0, 24'h0};
            repeat (4) tick();
        end
        n_vec++;
        if (status_o !== {flag, 6'd56, 1'b1, 8'hFF, 16'd263}) begin
            n_err++;
            $display("FAIL err_saturate: got %h expected %h", status_o,
                     {flag, 6'd56, 1'b1, 8'hFF, 16'd263});
        end
        flag = ~flag;
        data_input = {flag, 6'd0, 1'b0, 24'h0};
        repeat (4) tick();
        n_vec++;
        if (status_o !== {flag, 6'd0, 1'b0, 8'h00, 16'd264}) begin
            n_err++;
            $display("FAIL clear_after_sat: got %h expected %h", status_o,
                     {flag, 6'd0, 1'b0, 8'h00, 16'd264});
        end
    endtask

    task automatic test_skew();
        int pulses;
        flag = ~flag;
        data_input = {flag, 6'd63, 1'b0, 24'h000111};
        tick();
        data_input = {flag, 6'd63, 1'b0, 24'h000222};
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (reg_wr_o[0]) pulses++;
        end
        n_vec++;
        if (pulses != 1 || regs_o[23:0] !== 24'h000222) begin
            n_err++;
            $display("FAIL skew_write: got %0d strobes reg0 %h expected 1/000222", pulses, regs_o[23:0]);
        end
    endtask

    task automatic test_reset_mid();
        flag = ~flag;
        data_input = {flag, 6'd62, 1'b0, 24'h5A5A5A};
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if ({cpu_trig, reg_wr_o, status_o, led_o} !== '0 || regs_o !== 72'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got trig %b wr %b status %h led %h regs %h expected all 0",
                     cpu_trig, reg_wr_o, status_o, led_o, regs_o);
        end
        rst = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (regs_o !== 72'h0 || status_o !== {flag, 31'h0} || reg_wr_o !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_reinit: got regs %h status %h wr %b expected 0/%h/000",
                     regs_o, status_o, reg_wr_o, {flag, 31'h0});
        end
    endtask

    initial begin
        rst = 1'b1;
        data_input = 32'h0;
        busy_i = 1'b0;
        flag = 1'b0;
        test_reset();
        test_write();
        test_trigger();
        test_error();
        test_skew();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_decoder_param.md
Name: cmd_decoder_param

Overview:
- Parametrised successor to the GPIO command decoder. Takes the 32-bit PS→PL command word and decodes it into a trigger pulse plus NUM_REGS configuration registers (repetitions, samples, generator hops, ...).
- Sits between the AXI-GPIO output and the acquisition/generator blocks.
- New relative to the current decoder:
  - input synchroniser;
  - multi-bit stability check before executing a command;
  - configurable trigger pulse width, gated by a busy input;
  - per-register write strobes;
  - a 32-bit status/acknowledge word for CPU readback;
  - error counting.

Parameters:
- NUM_REGS, 3: number of data registers, 1..32. Register i lives at address 63-i (i=0→63, 1→62, 2→61).
- DATA_W, 24: register width, 1..24. Takes data_input[DATA_W-1:0].
- TRIG_LEN, 1: cpu_trig high time in clk cycles, ≥1.
- SYNC_STAGES, 2: synchroniser flops on data_input, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- data_input  in  32  command word. [31] toggle flag, [30:25] address, [24] ctrl bit, [23:0] data
- busy_i  in  1  acquisition in progress; triggers are refused while high
- cpu_trig  out  1  trigger pulse, TRIG_LEN cycles
- regs_o  out  NUM_REGS*DATA_W  register i occupies [i*DATA_W +: DATA_W]
- reg_wr_o  out  NUM_REGS  one-cycle write strobe per register
- status_o  out  32  [31] ack flag, [30:25] last address, [24] last cmd error, [23:16] error count, [15:0] command count
- led_o  out  8  [7] synced toggle flag, [6] last cmd was trigger, [5:0] last written data[5:0]

Behaviour:
- Reset (rst high at posedge):
  - all outputs 0; synchroniser flops 0; FSM→INIT.
  - Reset mid-command aborts the command with no register change.
- Synchroniser: every data_input bit passes through SYNC_STAGES flops; "sw" is the synchronised word. All decoding uses sw only.
- INIT:
  - wait SYNC_STAGES+1 cycles after reset release;
  - then ack_flag←sw[31] without executing anything, so a flag already at 1 is not a spurious command;
  - →IDLE.
- IDLE:
  - cpu_trig=0;
  - if sw[31]≠ack_flag, latch cap←sw and go →CAPTURE;
  - else stay.
- CAPTURE (stability check):
  - if sw≠cap: cap←sw, stay (skew still settling);
  - if sw=cap: execute, then:
    - →TRIG for an accepted trigger;
    - →IDLE for everything else.
  - ack_flag←cap[31] on execute in every case.
- Execute decode:
  - addr 0, ctrl 1, busy_i=0: trigger accepted. cpu_trig high from this edge for TRIG_LEN cycles; led_o[6]=1.
  - addr 0, ctrl 1, busy_i=1: refused. error flag set, err_cnt+1, no pulse.
  - addr 0, ctrl 0: clear err_cnt and the error flag; counts as a valid command.
  - addr 63-i with i<NUM_REGS:
    - reg i←cap[DATA_W-1:0];
    - reg_wr_o[i] high for exactly this one cycle;
    - led_o[5:0]←cap[5:0], led_o[6]=0.
  - any other address: error flag set, err_cnt+1, registers unchanged.
- Every executed command updates status_o:
  - cmd_cnt+1, wrapping at 16 bits;
  - last address field.
  - err_cnt saturates at 255.
- TRIG:
  - counter runs TRIG_LEN cycles, then cpu_trig=0 and →IDLE;
  - busy_i changes during TRIG are ignored.
- Latency: from a stable data_input change, the write/strobe/trigger edge is exactly SYNC_STAGES+2 clk edges later; status_o updates on the same edge.
- Toggle during CAPTURE/TRIG:
  - a single toggle is not lost; it is detected on return to IDLE.
  - two toggles before return cancel out and are dropped. The CPU must poll status_o[31] before issuing the next command.
- led_o[7]=sw[31] every cycle.

Test Plan:
- Reset, then data_input=0x80000000 held through INIT → no command executed; status_o[31]=1; cmd_cnt=0.
- From flag 0, write 0xFE0003E8 (addr 63, data 1000) → regs_o reg0=1000 and reg_wr_o[0] pulse exactly 4 edges later (SYNC_STAGES=2); status_o=0xFE000001; led_o[5:0]=0x28.
- With TRIG_LEN=3, busy_i=0, write 0x01000000 after flag 1 → cpu_trig high exactly 3 cycles; ack flag=0. Repeat with busy_i=1 → no pulse; status_o[24]=1; err_cnt=1.
- Write 0xF0000005 (addr 56, invalid for NUM_REGS=3) → registers unchanged; err_cnt+1. Then addr 0/ctrl 0 → err_cnt=0.
- Change bits [23:0] one cycle after flag toggles (skewed update) → the final stable value is written once; only one reg_wr_o pulse.
- Assert rst while in CAPTURE → no register change; all outputs 0; INIT re-entered.
